fifo_ptr_status: RTL and testbench

// Companion to the FIFO wrap-around pointer counter. It consumes the local binary pointer
// and the remote-domain gray pointer, and produces the status seen in one clock domain.
// It exports a gray-coded copy of the local pointer for the other domain and synchronises
// the remote gray pointer. It also derives full/empty, almost, occupancy level and a sticky overflow error.
// One instance sits in the write domain (full side) and one in the read domain (empty side).

---
 rtl/fifo_ptr_status.sv | 51 +++++
 tb/tb_fifo_ptr_status.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_status.sv
// fifo_ptr_status: gray export, remote-pointer synchroniser and full/empty/almost/level/overflow status for one FIFO domain
module fifo_ptr_status #(
  parameter int ADDR_WIDTH    = 7,
  parameter int SYNC_STAGES   = 2,
  parameter int IS_WR_SIDE    = 1,
  parameter int ALMOST_THRESH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH:0]   local_ptr_i,
  input  logic [ADDR_WIDTH:0]   remote_gray_i,
  output logic [ADDR_WIDTH:0]   local_gray_o,
  output logic [ADDR_WIDTH:0]   sync_ptr_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  flag_o,
  output logic                  almost_o,
  output logic                  overflow_err_o
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH  = PW'(1) << ADDR_WIDTH;
  localparam logic [PW-1:0] THRESH = PW'(ALMOST_THRESH);
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_ptr_d, sync_ptr_q, local_gray_q;
  logic          overflow_q;
  // each binary bit is the parity of all gray bits at or above it
  for (genvar i = 0; i < PW; i++) begin : g_g2b
    assign sync_ptr_d[i] = ^sync_q[SYNC_STAGES-1][PW-1:i];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      sync_ptr_q   <= '0;
      local_gray_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      sync_q[0] <= remote_gray_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sync_ptr_q   <= sync_ptr_d;
      local_gray_q <= local_ptr_i ^ (local_ptr_i >> 1);
      overflow_q   <= overflow_q | (level_o > DEPTH);
    end
  end
  always_comb begin
    level_o  = (IS_WR_SIDE != 0) ? local_ptr_i - sync_ptr_q : sync_ptr_q - local_ptr_i;
    flag_o   = (IS_WR_SIDE != 0) ? (level_o == DEPTH) : (level_o == '0);
    almost_o = (IS_WR_SIDE != 0) ? (level_o >= DEPTH - THRESH) : (level_o <= THRESH);
  end
  assign local_gray_o   = local_gray_q;
  assign sync_ptr_o     = sync_ptr_q;
  assign overflow_err_o = overflow_q;
endmodule

// File: tb/tb_fifo_ptr_status.sv
// tb_fifo_ptr_status: scoreboard bench driving a write-side and a read-side instance against a pointer-arithmetic model
module tb_fifo_ptr_status;
  localparam int SS = 2;
  typedef struct {
    int lg, sp, lv, fl, al, ov;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] loc [2];
  logic [7:0] rg  [2];
  logic [7:0] lg_o [2];
  logic [7:0] sp_o [2];
  logic [7:0] lv_o [2];
  logic       fl_o [2];
  logic       al_o [2];
  logic       ov_o [2];
  exp_t       sb [2][$];
  int         total = 0;
  int         bad   = 0;
  int         m_lgray [2];
  int         m_sync  [2];
  int         m_ovf   [2];
  int         m_hist  [2][$];

  always #5 clk = ~clk;

  fifo_ptr_status #(.ADDR_WIDTH(7), .SYNC_STAGES(SS), .IS_WR_SIDE(0), .ALMOST_THRESH(4)) u_rd (
    .clk_i(clk), .rst_i(rst), .local_ptr_i(loc[0]), .remote_gray_i(rg[0]),
    .local_gray_o(lg_o[0]), .sync_ptr_o(sp_o[0]), .level_o(lv_o[0]),
    .flag_o(fl_o[0]), .almost_o(al_o[0]), .overflow_err_o(ov_o[0]));

  fifo_ptr_status #(.ADDR_WIDTH(7), .SYNC_STAGES(SS), .IS_WR_SIDE(1), .ALMOST_THRESH(4)) u_wr (
    .clk_i(clk), .rst_i(rst), .local_ptr_i(loc[1]), .remote_gray_i(rg[1]),
    .local_gray_o(lg_o[1]), .sync_ptr_o(sp_o[1]), .level_o(lv_o[1]),
    .flag_o(fl_o[1]), .almost_o(al_o[1]), .overflow_err_o(ov_o[1]));

  function automatic int to_gray(int b);
    return (b ^ (b >> 1)) & 255;
  endfunction

  // inverse gray found by search, independent of any bitwise decode
  function automatic int from_gray(int g);
    for (int v = 0; v < 256; v++) if (to_gray(v) == g) return v;
    return -1;
  endfunction

  function automatic int level_of(int s, int l, int sy);
    return (s == 1) ? ((l - sy) & 255) : ((sy - l) & 255);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_lgray[s] = 0; m_sync[s] = 0; m_ovf[s] = 0;
      m_hist[s].delete();
      for (int k = 0; k <= SS; k++) m_hist[s].push_back(0);
    end
  endtask

  task automatic step(input logic r, input int lw, input int gw, input int lr, input int gr);
    @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        m_lgray[s] = 0; m_sync[s] = 0; m_ovf[s] = 0;
        for (int k = 0; k <= SS; k++) m_hist[s][k] = 0;
      end else begin
        if (level_of(s, int'(loc[s]), m_sync[s]) > 128) m_ovf[s] = 1;
        m_lgray[s] = to_gray(int'(loc[s]));
        m_hist[s].push_back(int'(rg[s]));
        void'(m_hist[s].pop_front());
        m_sync[s] = from_gray(m_hist[s][0]);
      end
    end
    #1;
    rst = r;
    loc[1] = 8'(lw); rg[1] = 8'(gw);
    loc[0] = 8'(lr); rg[0] = 8'(gr);
    for (int s = 0; s < 2; s++) begin
      exp_t e;
      int lv;
      lv   = level_of(s, int'(loc[s]), m_sync[s]);
      e.lg = m_lgray[s];
      e.sp = m_sync[s];
      e.lv = lv;
      e.fl = (s == 1) ? int'(lv == 128) : int'(lv == 0);
      e.al = (s == 1) ? int'(lv >= 124) : int'(lv <= 4);
      e.ov = m_ovf[s];
      sb[s].push_back(e);
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (sb[s].size() > 0) begin
          exp_t e;
          string p;
          e = sb[s].pop_front();
          p = (s == 1) ? "wr" : "rd";
          chk({p, ".local_gray"}, int'(lg_o[s]), e.lg);
          chk({p, ".sync_ptr"},   int'(sp_o[s]), e.sp);
          chk({p, ".level"},      int'(lv_o[s]), e.lv);
          chk({p, ".flag"},       int'(fl_o[s]), e.fl);
          chk({p, ".almost"},     int'(al_o[s]), e.al);
          chk({p, ".overflow"},   int'(ov_o[s]), e.ov);
        end
      end
    end
  end

  initial begin : stim
    int bw, br, lw, lr;
    loc[0] = 0; loc[1] = 0; rg[0] = 0; rg[1] = 0;
    model_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 8'h05, 0, 0, 0);
    step(0, 8'h80, 0, 0, 0);
    step(0, 8'h10, 0, 0, 0);
    step(0, 8'h10, 8'h02, 0, 0);
    repeat (4) step(0, 8'h10, 8'h02, 0, 0);
    repeat (4) step(0, 8'h10, 8'h18, 0, 0);
    repeat (2) step(0, 8'h90, 8'h18, 0, 0);
    repeat (2) step(0, 8'h8F, 8'h18, 0, 0);
    step(0, 8'h10, 8'h18, 0, 0);
    repeat (4) step(0, 8'h10, 8'h81, 0, 0);
    repeat (2) step(0, 8'h05, 8'h81, 0, 0);
    repeat (4) step(0, 8'h05, 8'h81, 0, 8'h07);
    repeat (2) step(0, 8'h05, 8'h81, 8'hFE, 8'h07);
    repeat (4) step(0, 8'h05, 8'h81, 8'hFE, 8'h03);
    repeat (2) step(0, 8'h05, 8'h81, 8'h02, 8'h03);
    repeat (4) step(0, 8'h10, 8'h18, 8'h02, 8'h03);
    repeat (2) step(0, 8'h91, 8'h18, 8'h02, 8'h03);
    repeat (4) step(0, 8'h10, 8'h18, 8'h02, 8'h03);
    step(1, 8'h10, 8'h18, 8'h02, 8'h03);
    repeat (2) step(0, 8'h10, 8'h18, 0, 0);
    bw = 0; br = 0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) bw = (bw + $urandom_range(0, 3)) & 255;
      if ($urandom_range(0, 3) == 0) br = (br + $urandom_range(0, 3)) & 255;
      lw = (bw + $urandom_range(0, 130)) & 255;
      lr = (br - $urandom_range(0, 132)) & 255;
      step($urandom_range(0, 49) == 0, lw, to_gray(bw), lr, to_gray(br));
    end
    repeat (3) @(posedge clk);
    if (sb[0].size() != 0 || sb[1].size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left, expected 0", sb[0].size() + sb[1].size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
